// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types and constants for the FFT frame sequencer
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_RESULT = 2'd2
  } seq_state_e;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FFT_PTS    = 1024;
  localparam int DEF_PTS_W      = 11;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam logic [1:0] SINK_ERR_NONE = 2'b00;

endpackage

// File: rtl/fft_frame_sequencer_fifo.sv
// rtl/fft_frame_sequencer_fifo.sv - first-word-fall-through sample FIFO
module sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full (wrapped once) from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Pointer advance; push and pop in the same cycle are both honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frames a sample stream onto the FFT core Avalon-ST sink
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FFT_PTS    = DEF_FFT_PTS,
  parameter int PTS_W      = DEF_PTS_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              enable,
  input  logic              inverse_cfg,
  input  logic              clear_ovf,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [1:0]        sink_error,
  output logic              inverse,
  output logic [PTS_W-1:0]  fft_pts,
  input  logic              source_valid,
  input  logic              source_eop,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam logic [PTS_W-1:0] LAST_BEAT = PTS_W'(FFT_PTS - 1);

  seq_state_e        state_q;
  logic [PTS_W-1:0]  beat_cnt_q;
  logic              inverse_q;
  logic              frame_done_q;
  logic              overflow_q;
  logic              overflow_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              beat;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sample_valid),
    .pop   (beat),
    .din   (sample_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Beats are only offered while streaming; starvation simply drops valid.
  assign sink_valid = (state_q == STREAM) && !fifo_empty;
  assign beat       = sink_valid && sink_ready;
  assign sink_sop   = sink_valid && (beat_cnt_q == '0);
  assign sink_eop   = sink_valid && (beat_cnt_q == LAST_BEAT);
  assign sink_real  = fifo_head;
  assign sink_imag  = '0;
  assign sink_error = SINK_ERR_NONE;
  assign fft_pts    = PTS_W'(FFT_PTS);
  assign inverse    = inverse_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

  // Frame FSM: start on enable with data, count beats, wait for result eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      inverse_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state_q    <= STREAM;
            inverse_q  <= inverse_cfg;
            beat_cnt_q <= '0;
          end
        end
        STREAM: begin
          if (beat) begin
            if (beat_cnt_q == LAST_BEAT) begin
              state_q    <= WAIT_RESULT;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + PTS_W'(1);
            end
          end
        end
        WAIT_RESULT: begin
          if (source_valid && source_eop) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_ovf)                overflow_d = 1'b0;
    if (sample_valid && fifo_full) overflow_d = 1'b1;
  end

  // Overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        enable = 1'b0;
  logic        inverse_cfg = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        sink_ready = 1'b1;
  logic        sink_valid, sink_sop, sink_eop;
  logic [15:0] sink_real, sink_imag;
  logic [1:0]  sink_error;
  logic        inverse;
  logic [3:0]  fft_pts;
  logic        source_valid = 1'b0;
  logic        source_eop = 1'b0;
  logic        frame_done, overflow, busy;

  fft_frame_sequencer #(
    .DATA_W     (16),
    .FFT_PTS    (8),
    .PTS_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .enable       (enable),
    .inverse_cfg  (inverse_cfg),
    .clear_ovf    (clear_ovf),
    .sink_ready   (sink_ready),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_error   (sink_error),
    .inverse      (inverse),
    .fft_pts      (fft_pts),
    .source_valid (source_valid),
    .source_eop   (source_eop),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        srcv;
    logic [4:0]  exp_flags;
    logic [15:0] exp_real;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] bq[$];
  logic        sq[$];
  logic        eq[$];
  logic        rdy_pat[6];
  logic [15:0] ev[8];

  logic        prev_stall;
  logic [15:0] prev_real;
  logic        prev_sop, prev_eop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_in    = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic run_stream(input int base, input int n, input int push_every, input bit stall,
                            input int gap_at, input int gap_len, input int drop_en_at,
                            input bit toggle_inv, input int target);
    int  cyc;
    int  pushed;
    int  gap_cnt;
    bit  do_push;
    logic inv0;
    cyc = 0; pushed = 0; gap_cnt = 0; prev_stall = 1'b0;
    inv0 = inverse_cfg;
    while (cyc < 400 && (pushed < n || bq.size() < target)) begin
      do_push = 1'b0;
      if (pushed < n) begin
        if (pushed == gap_at && gap_cnt < gap_len) gap_cnt++;
        else if (cyc % push_every == push_every - 1) do_push = 1'b1;
      end
      if (pushed == drop_en_at) enable = 1'b0;
      if (toggle_inv && pushed == n / 2) inverse_cfg = ~inv0;
      sample_valid = do_push;
      sample_in    = 16'(base + pushed);
      sink_ready   = stall ? rdy_pat[cyc % 6] : 1'b1;
      if (gap_len > 0 && pushed == gap_at && gap_cnt >= 3 && gap_cnt < gap_len)
        chk("gap_valid_low", sink_valid, 1'b0);
      if (prev_stall)
        chk("stall_hold", {sink_valid, sink_sop, sink_eop, sink_real},
            {1'b1, prev_sop, prev_eop, prev_real});
      if (sink_valid && sink_ready) begin
        bq.push_back(sink_real);
        sq.push_back(sink_sop);
        eq.push_back(sink_eop);
      end
      prev_stall = sink_valid && !sink_ready;
      prev_real  = sink_real;
      prev_sop   = sink_sop;
      prev_eop   = sink_eop;
      tick();
      if (do_push) pushed++;
      cyc++;
    end
    sample_valid = 1'b0;
    sink_ready   = 1'b1;
    if (cyc >= 400) chk("stream_timeout", 32'(bq.size()), 32'(target));
  endtask

  task automatic check_beats(input string name, input logic [15:0] e[8]);
    chk({name, "_count"}, 32'(bq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < bq.size()) begin
        chk({name, "_data"}, bq[i], e[i]);
        chk({name, "_sop"}, sq[i], (i == 0));
        chk({name, "_eop"}, eq[i], (i == 7));
      end
    end
  endtask

  task automatic finish_frame();
    chk("wait_result_state", {busy, sink_valid}, 2'b10);
    source_valid = 1'b1;
    source_eop   = 1'b1;
    tick();
    source_valid = 1'b0;
    source_eop   = 1'b0;
    chk("frame_done_pulse", {frame_done, busy}, 2'b10);
    tick();
    chk("frame_done_clear", frame_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    tbl[0]  = '{1'b1, 16'd1, 1'b0, 5'b00000, 16'd0};
    tbl[1]  = '{1'b1, 16'd2, 1'b0, 5'b00000, 16'd0};
    tbl[2]  = '{1'b1, 16'd3, 1'b0, 5'b11010, 16'd1};
    tbl[3]  = '{1'b1, 16'd4, 1'b0, 5'b10010, 16'd2};
    tbl[4]  = '{1'b1, 16'd5, 1'b0, 5'b10010, 16'd3};
    tbl[5]  = '{1'b1, 16'd6, 1'b0, 5'b10010, 16'd4};
    tbl[6]  = '{1'b1, 16'd7, 1'b0, 5'b10010, 16'd5};
    tbl[7]  = '{1'b1, 16'd8, 1'b0, 5'b10010, 16'd6};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 5'b10010, 16'd7};
    tbl[9]  = '{1'b0, 16'd0, 1'b0, 5'b10110, 16'd8};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 5'b00010, 16'd0};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 5'b00010, 16'd0};
    tbl[12] = '{1'b0, 16'd0, 1'b0, 5'b00001, 16'd0};
    tbl[13] = '{1'b0, 16'd0, 1'b0, 5'b00000, 16'd0};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("reset_outputs", {sink_valid, sink_sop, sink_eop, inverse, frame_done, overflow, busy}, 7'd0);
    chk("reset_consts", {sink_imag, sink_error, fft_pts}, {16'd0, 2'b00, 4'd8});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Frame with continuous ready, cycle by cycle
    enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sample_valid = tbl[i].sv;
      sample_in    = tbl[i].sd;
      source_valid = tbl[i].srcv;
      source_eop   = tbl[i].srcv;
      n_cmp++;
      if ({sink_valid, sink_sop, sink_eop, busy, frame_done} !== tbl[i].exp_flags ||
          (tbl[i].exp_flags[4] && sink_real !== tbl[i].exp_real)) begin
        n_fail++;
        $display("FAIL table_row%0d: got flags %b real %0d expected flags %b real %0d",
                 i, {sink_valid, sink_sop, sink_eop, busy, frame_done}, sink_real,
                 tbl[i].exp_flags, tbl[i].exp_real);
      end
      tick();
    end
    sample_valid = 1'b0;
    source_valid = 1'b0;
    source_eop   = 1'b0;

    // Backpressure: ready pattern 1,0,0,1,0,1 with paced pushes
    bq.delete(); sq.delete(); eq.delete();
    run_stream(1, 8, 3, 1'b1, -1, 0, -1, 1'b0, 8);
    ev = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    check_beats("stall", ev);
    chk("stall_no_ovf", overflow, 1'b0);

    // Overflow while held in WAIT_RESULT
    enable = 1'b0;
    push_one(16'd11);
    push_one(16'd12);
    push_one(16'd13);
    push_one(16'd14);
    chk("ovf_before_drop", overflow, 1'b0);
    push_one(16'd15);
    chk("ovf_after_drop", overflow, 1'b1);
    sample_valid = 1'b1;
    sample_in    = 16'd16;
    clear_ovf    = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("ovf_set_wins", overflow, 1'b1);
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Next frame from buffered samples; inverse latched then toggled mid-frame
    enable      = 1'b1;
    inverse_cfg = 1'b1;
    finish_frame();
    bq.delete(); sq.delete(); eq.delete();
    run_stream(20, 4, 3, 1'b0, -1, 0, -1, 1'b1, 8);
    ev = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd20, 16'd21, 16'd22, 16'd23};
    check_beats("after_ovf", ev);
    chk("inverse_held", inverse, 1'b1);
    chk("ovf_stays_clear", overflow, 1'b0);
    enable = 1'b0;
    finish_frame();

    // Starvation gap with enable dropped mid-frame; inverse now 0
    inverse_cfg = 1'b0;
    enable      = 1'b1;
    bq.delete(); sq.delete(); eq.delete();
    run_stream(31, 8, 1, 1'b0, 3, 10, 3, 1'b0, 8);
    ev = '{16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 16'd36, 16'd37, 16'd38};
    check_beats("starve", ev);
    chk("inverse_second", inverse, 1'b0);
    finish_frame();

    // Asynchronous reset during beat 4
    inverse_cfg = 1'b1;
    enable      = 1'b1;
    bq.delete(); sq.delete(); eq.delete();
    for (int c = 0; c < 40; c++) begin
      sample_valid = (c < 8);
      sample_in    = 16'(41 + c);
      if (sink_valid && sink_ready) begin
        bq.push_back(sink_real);
        sq.push_back(sink_sop);
        eq.push_back(sink_eop);
      end
      if (bq.size() == 4) break;
      tick();
    end
    chk("pre_reset_beat4", {sink_valid, sink_real, inverse}, {1'b1, 16'd44, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {sink_valid, sink_sop, sink_eop, inverse, frame_done, overflow, busy}, 7'd0);
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {busy, sink_valid}, 2'b00);
    bq.delete(); sq.delete(); eq.delete();
    run_stream(51, 8, 1, 1'b0, -1, 0, -1, 1'b0, 8);
    ev = '{16'd51, 16'd52, 16'd53, 16'd54, 16'd55, 16'd56, 16'd57, 16'd58};
    check_beats("post_reset", ev);
    finish_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences a continuous audio sample stream into fixed-length frames on the FFT core's Avalon-ST sink interface. It buffers incoming samples in a small FIFO and drives sink_valid, sink_sop and sink_eop with correct framing under sink_ready backpressure. It latches the per-frame configuration (inverse, fft_pts) and waits for the core's source end-of-packet before starting the next frame. It sits between the audio capture path and the FFT core, replacing free-running count-based framing.

Parameters:
DATA_W, 16, sample and real/imag data width
FFT_PTS, 1024, points per frame; fft_pts output value
PTS_W, 11, width of fft_pts and the beat counter; must hold FFT_PTS
FIFO_DEPTH, 16, sample FIFO entries; power of two

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_in  in  DATA_W  audio sample
sample_valid  in  1  one-cycle strobe; sample_in is valid
enable  in  1  permits a new frame to start
inverse_cfg  in  1  requested transform direction, latched at frame start
clear_ovf  in  1  clears overflow
sink_ready  in  1  from FFT core
sink_valid  out  1  beat valid to FFT core
sink_sop  out  1  first beat of frame
sink_eop  out  1  last beat of frame
sink_real  out  DATA_W  FIFO head sample
sink_imag  out  DATA_W  constant 0
sink_error  out  2  constant 2'b00
inverse  out  1  latched direction for current frame
fft_pts  out  PTS_W  constant FFT_PTS
source_valid  in  1  from FFT core output
source_eop  in  1  from FFT core output
frame_done  out  1  one-cycle pulse when the result frame has fully emerged
overflow  out  1  sticky; a sample was dropped
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, FIFO empty, beat_cnt 0, and sink_valid, sink_sop, sink_eop, inverse, frame_done, overflow all 0. sink_imag, sink_error and fft_pts are constants.
- FIFO push:
  - Occurs when sample_valid && !full.
  - If sample_valid && full, the sample is dropped and overflow is set to 1. The push is not rescued by a simultaneous pop.
  - overflow clears on clear_ovf. If set and clear occur in the same cycle, set wins.
  - Pushing continues in every state.
- FIFO pop occurs on a beat: sink_valid && sink_ready. Simultaneous push and pop are both honoured. A sample pushed at edge t appears at the head at edge t+1.
- FSM states:
  - IDLE: if enable && !empty, go to STREAM at the next edge, latch inverse <= inverse_cfg, and set beat_cnt <= 0.
  - STREAM:
    - sink_valid = !empty and sink_real = FIFO head.
    - sink_sop = sink_valid && beat_cnt==0.
    - sink_eop = sink_valid && beat_cnt==FFT_PTS-1.
    - Each beat increments beat_cnt.
    - The beat with eop goes to WAIT_RESULT.
  - WAIT_RESULT: sink_valid = 0. When source_valid && source_eop, pulse frame_done for one cycle and go to IDLE.
- Backpressure: while sink_valid && !sink_ready, sink_real, sink_sop and sink_eop hold stable. No sample is lost or duplicated.
- Starvation: if the FIFO empties mid-frame, sink_valid deasserts and beat_cnt holds. sop is not re-asserted on resume.
- Config stability:
  - inverse changes only on the IDLE->STREAM transition.
  - enable deassertion mid-frame does not abort; the frame completes.
  - Only reset aborts a frame.
- Back-to-back frames: the earliest next frame start is IDLE at the cycle after frame_done. Minimum gap is one cycle.
- Counter widths: beat_cnt is PTS_W bits and never exceeds FFT_PTS-1. FIFO pointers carry log2(FIFO_DEPTH)+1 bits for the full/empty distinction.

Decomposition:
- Package fft_ctrl_pkg: FSM state typedef (IDLE, STREAM, WAIT_RESULT), default FFT_PTS/DATA_W constants, SINK_ERR_NONE = 2'b00.
- Sub-module sample_fifo (DATA_W, FIFO_DEPTH), with the following ports: push, pop, din, dout (head, first-word-fall-through), full, empty. It is reset by the same async rst_n.

Test Plan:
- Frame with FFT_PTS=8, sink_ready=1, samples 1..8 pushed, enable=1 -> 8 beats; sop only with 1, eop only with 8, then busy=1 until source_eop; frame_done is a one-cycle pulse, then IDLE.
- Same stream with sink_ready pattern 1,0,0,1,0,1... -> sink_real stable while stalled; delivered sequence is exactly 1..8; no extra beats.
- FIFO_DEPTH=4, held in WAIT_RESULT, push 5 samples -> overflow=1 after the 5th, which is dropped; the next frame starts with sample 1; clear_ovf pulse -> overflow=0.
- inverse_cfg=1 at start, toggled mid-frame -> inverse stays 1 until the next IDLE->STREAM; the second frame with inverse_cfg=0 -> inverse=0.
- Push only 3 samples, pause 10 cycles, push the remaining 5 -> sink_valid low during the gap; sop asserted once; eop on the 8th beat.
- rst_n low during beat 4 of STREAM -> all outputs 0 asynchronously; after release, FIFO empty and IDLE; the new frame starts with sop on the first new sample.
